// File: rtl/uart_rx_os.sv
// 16x-oversampling UART receiver: 8N1/8E1/8O1 frames, 3-sample majority vote,
// single holding register with frame/parity error and sticky overrun status.
module uart_rx_os #(
    parameter int DATA_BITS   = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 baud_os,
    input  logic                 rxd,
    input  logic                 par_en,
    input  logic                 par_odd,
    input  logic                 rx_rd,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun
);
    localparam int BCW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t                 state, state_next;
    logic [SYNC_STAGES-1:0] sync;
    logic                   rxd_s;
    logic                   baud_os_q;
    logic                   tick, adv;
    logic [3:0]             tc;
    logic [BCW-1:0]         bc;
    logic                   s7, s8, maj;
    logic                   armed;
    logic [DATA_BITS-1:0]   shreg;
    logic                   par_mis;
    logic                   commit, bit_end, start_det, frame_done;

    assign rxd_s = sync[SYNC_STAGES-1];
    assign tick  = baud_os ^ baud_os_q;
    assign adv   = tick & en;
    assign maj   = (s7 & s8) | (s7 & rxd_s) | (s8 & rxd_s);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (!en) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE:    if (start_det) state_next = START;
                START:   if (commit && maj) state_next = IDLE;
                         else if (bit_end)  state_next = DATA;
                DATA:    if (bit_end && bc == BCW'(DATA_BITS-1))
                             state_next = par_en ? PARITY : STOP;
                PARITY:  if (bit_end) state_next = STOP;
                STOP:    if (commit)  state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    always_comb begin
        commit     = adv && (tc == 4'd9) && (state != IDLE);
        bit_end    = adv && (tc == 4'd15);
        // After a frame, a new start needs the line to have gone high first (break handling).
        start_det  = (state == IDLE) && adv && !rxd_s && armed;
        frame_done = commit && (state == STOP);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync       <= '1;
            baud_os_q  <= 1'b0;
            armed      <= 1'b1;
            tc         <= '0;
            bc         <= '0;
            s7         <= 1'b1;
            s8         <= 1'b1;
            shreg      <= '0;
            par_mis    <= 1'b0;
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            sync      <= {sync[SYNC_STAGES-2:0], rxd};
            baud_os_q <= baud_os;

            if (frame_done) armed <= 1'b0;
            else if (rxd_s) armed <= 1'b1;

            if (state == IDLE || !en) tc <= '0;
            else if (adv)             tc <= tc + 4'd1;

            if (adv && tc == 4'd7) s7 <= rxd_s;
            if (adv && tc == 4'd8) s8 <= rxd_s;

            if (state == START) bc <= '0;
            else if (state == DATA && bit_end && bc != BCW'(DATA_BITS-1)) bc <= bc + BCW'(1);

            if (start_det)                      shreg     <= '0;
            else if (commit && state == DATA)   shreg[bc] <= maj;

            if (start_det)                      par_mis <= 1'b0;
            else if (commit && state == PARITY) par_mis <= maj ^ (^shreg) ^ par_odd;

            if (frame_done) begin
                rx_data    <= shreg;
                frame_err  <= ~maj;
                parity_err <= par_mis;
                rx_valid   <= 1'b1;
                if (rx_valid && !rx_rd) overrun <= 1'b1;
                else if (rx_rd)         overrun <= 1'b0;
            end else if (rx_rd && rx_valid) begin
                rx_valid <= 1'b0;
                overrun  <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_uart_rx_os.sv
// Directed bench for uart_rx_os: baud_os toggles every 4 clk, one bit = 64 clk.
module tb_uart_rx_os;
    logic       clk = 1'b0, rst = 1'b1, en = 1'b1, baud_os = 1'b0, rxd = 1'b1;
    logic       par_en = 1'b0, par_odd = 1'b0, rx_rd = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid, frame_err, parity_err, overrun;
    int         n_chk = 0, n_fail = 0;
    int         lat = 0;

    uart_rx_os #(.DATA_BITS(8), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst), .en(en), .baud_os(baud_os), .rxd(rxd),
        .par_en(par_en), .par_odd(par_odd), .rx_rd(rx_rd),
        .rx_data(rx_data), .rx_valid(rx_valid), .frame_err(frame_err),
        .parity_err(parity_err), .overrun(overrun)
    );

    always #5 clk = ~clk;

    initial forever begin
        repeat (4) @(posedge clk);
        #1 baud_os = ~baud_os;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        rxd = b;
        cyc(64);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic pb_en, input logic pb, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        if (pb_en) send_bit(pb);
        send_bit(stop);
        rxd = 1'b1;
    endtask

    task automatic pop();
        rx_rd = 1'b1;
        cyc(1);
        rx_rd = 1'b0;
    endtask

    task automatic measure(output int k);
        k = 0;
        while (!rx_valid && k < 1000) begin
            cyc(1);
            k++;
        end
    endtask

    initial begin
        cyc(3);
        chk("rst_data", rx_data, 0);
        chk("rst_valid", rx_valid, 0);
        chk("rst_ferr", frame_err, 0);
        chk("rst_perr", parity_err, 0);
        chk("rst_ovr", overrun, 0);
        rst = 1'b0;
        cyc(20);

        // 0xA5 8N1, completion ~9.6 bit times after the start edge
        fork
            send_frame(8'hA5, 1'b0, 1'b0, 1'b1);
            measure(lat);
        join
        chk("a5_latency", (lat >= 600 && lat <= 640), 1);
        chk("a5_data", rx_data, 8'hA5);
        chk("a5_valid", rx_valid, 1);
        chk("a5_ferr", frame_err, 0);
        chk("a5_perr", parity_err, 0);
        chk("a5_ovr", overrun, 0);
        pop();
        chk("a5_pop_valid", rx_valid, 0);
        chk("a5_pop_hold", rx_data, 8'hA5);

        // even parity: 0x03 has even ones, parity bit must be 0
        par_en = 1'b1; par_odd = 1'b0;
        send_frame(8'h03, 1'b1, 1'b1, 1'b1);
        chk("even_bad_perr", parity_err, 1);
        chk("even_bad_data", rx_data, 8'h03);
        chk("even_bad_ferr", frame_err, 0);
        pop();
        send_frame(8'h03, 1'b1, 1'b0, 1'b1);
        chk("even_ok_perr", parity_err, 0);
        chk("even_ok_data", rx_data, 8'h03);
        pop();
        par_odd = 1'b1;
        send_frame(8'h03, 1'b1, 1'b1, 1'b1);
        chk("odd_ok_perr", parity_err, 0);
        pop();
        par_en = 1'b0; par_odd = 1'b0;

        // 3-tick low glitch is a false start
        rxd = 1'b0; cyc(12); rxd = 1'b1; cyc(200);
        chk("glitch_valid", rx_valid, 0);
        send_frame(8'h5A, 1'b0, 1'b0, 1'b1);
        chk("5a_data", rx_data, 8'h5A);
        chk("5a_valid", rx_valid, 1);
        pop();

        // back-to-back without a read -> overrun
        fork
            begin send_frame(8'h11, 1'b0, 1'b0, 1'b1); send_frame(8'h22, 1'b0, 1'b0, 1'b1); end
        join
        chk("b2b_data", rx_data, 8'h22);
        chk("b2b_valid", rx_valid, 1);
        chk("b2b_ovr", overrun, 1);
        pop();
        chk("b2b_pop_valid", rx_valid, 0);
        chk("b2b_pop_ovr", overrun, 0);
        chk("b2b_pop_hold", rx_data, 8'h22);

        // read coinciding with the second completion cycle -> no overrun
        fork
            begin send_frame(8'h11, 1'b0, 1'b0, 1'b1); send_frame(8'h22, 1'b0, 1'b0, 1'b1); end
            begin measure(lat); cyc(639); rx_rd = 1'b1; cyc(1); rx_rd = 1'b0; end
        join
        chk("coin_data", rx_data, 8'h22);
        chk("coin_valid", rx_valid, 1);
        chk("coin_ovr", overrun, 0);
        pop();

        // stop bit low
        send_frame(8'hFF, 1'b0, 1'b0, 1'b0);
        cyc(10);
        chk("stop0_ferr", frame_err, 1);
        chk("stop0_data", rx_data, 8'hFF);
        chk("stop0_valid", rx_valid, 1);
        pop();

        // 20-bit break -> exactly one all-zero frame
        rxd = 1'b0; cyc(1280); rxd = 1'b1; cyc(200);
        chk("brk_data", rx_data, 8'h00);
        chk("brk_ferr", frame_err, 1);
        chk("brk_valid", rx_valid, 1);
        chk("brk_ovr", overrun, 0);
        pop();

        // one-tick noise pulse near the middle of data bit 2
        fork
            send_frame(8'h00, 1'b0, 1'b0, 1'b1);
            begin cyc(64*3 + 33); rxd = 1'b1; cyc(4); rxd = 1'b0; end
        join
        chk("noise_data", rx_data, 8'h00);
        chk("noise_ferr", frame_err, 0);
        chk("noise_valid", rx_valid, 1);
        pop();

        // en dropped mid-frame
        fork
            send_frame(8'h77, 1'b0, 1'b0, 1'b1);
            begin cyc(300); en = 1'b0; end
        join
        en = 1'b1;
        cyc(100);
        chk("en_valid", rx_valid, 0);
        chk("en_data", rx_data, 8'h00);
        chk("en_ferr", frame_err, 0);

        // async reset mid-frame clears everything
        send_frame(8'h3C, 1'b0, 1'b0, 1'b1);
        chk("pre_rst_data", rx_data, 8'h3C);
        fork
            send_frame(8'h81, 1'b0, 1'b0, 1'b1);
            begin
                cyc(300);
                #2 rst = 1'b1;
                #1;
                chk("arst_data", rx_data, 0);
                chk("arst_valid", rx_valid, 0);
                chk("arst_ferr", frame_err, 0);
                chk("arst_perr", parity_err, 0);
                chk("arst_ovr", overrun, 0);
            end
        join
        cyc(2);
        rst = 1'b0;
        cyc(100);
        chk("post_rst_valid", rx_valid, 0);
        chk("post_rst_data", rx_data, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/uart_rx_os.md
Name: uart_rx_os

Overview:
16x-oversampling UART receiver sitting directly downstream of the baud generator's fast oversample output. It consumes the generator's toggling oversample clock, not a pulse; every transition of that signal is one sample tick, i.e. 1/16 bit period. It deserialises 8N1/8E1/8O1 frames from the pad, applies 3-sample majority voting, and presents bytes through a single holding register with error and overrun status to the bus-side register file.

Parameters:
DATA_BITS, 8, data bits per frame (LSB first); the rx_data width equals DATA_BITS.
SYNC_STAGES, 2, flip-flop stages on rxd before use (minimum 2).

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
en  in  1  receiver enable; 0 forces IDLE synchronously, holding register retained
baud_os  in  1  toggling oversample clock from baud generator; each edge = 1 tick
rxd  in  1  serial input, asynchronous, idle high
par_en  in  1  1 = parity bit present after data
par_odd  in  1  1 = odd parity, 0 = even (ignored when par_en=0)
rx_rd  in  1  1-cycle pop strobe from bus side
rx_data  out  DATA_BITS  received byte
rx_valid  out  1  holding register full
frame_err  out  1  stop bit sampled 0 for the frame in rx_data
parity_err  out  1  parity mismatch for the frame in rx_data
overrun  out  1  sticky: frame completed while rx_valid=1 and no rx_rd

Behaviour:
- Reset: rx_data=0, rx_valid=0, frame_err=0, parity_err=0, overrun=0, state=IDLE, tick counter=0, bit counter=0, sync flops=1, baud_os_q=0.
- tick = baud_os XOR baud_os_q (registered copy). All FSM advances occur only on clk cycles where tick=1 and en=1.
- rxd_s = rxd after SYNC_STAGES flops. Samples use rxd_s only.
- Tick counter tc, 4 bits, 0..15, wraps 15->0 and advances once per tick within a bit. Samples are taken at tc=7, 8 and 9. The bit value is the majority of those 3 samples, committed at tc=9.
- FSM:
  IDLE: on tick with rxd_s=0 -> START, tc=0.
  START: at commit, majority=1 -> IDLE (false start, no status change); majority=0 -> continue. At tc=15 -> DATA, bit counter=0.
  DATA: at commit, shift the majority value into bit[bit counter], LSB first. At tc=15: bit counter==DATA_BITS-1 -> PARITY if par_en, else STOP; otherwise increment bit counter.
  PARITY: at commit, compute expected parity = XOR(data) XOR par_odd; store the mismatch. At tc=15 -> STOP.
  STOP: at commit, complete the frame and go to IDLE immediately; the remaining 6 ticks are not waited for, which allows the next start to resync.
- Frame completion, registered in the cycle after the commit tick:
  - rx_data <= shift register.
  - frame_err <= (stop majority==0).
  - parity_err <= mismatch (0 when par_en=0).
  - rx_valid <= 1.
  - If rx_valid was already 1 and rx_rd is not asserted in that commit cycle, overrun <= 1 and the data is still overwritten with the new frame.
- rx_rd while rx_valid=1: rx_valid<=0 and overrun<=0 next cycle. rx_data, frame_err and parity_err hold their values.
- rx_rd in the same cycle as completion: the new frame loads, rx_valid stays 1, no overrun, and overrun is cleared.
- rx_rd while rx_valid=0: no effect.
- Break (line held 0): data all 0, frame_err=1, then the FSM returns to IDLE. It retriggers START only after rxd_s returns to 1 and falls again, so IDLE additionally requires rxd_s to have been 1 since the last frame.
- en falling mid-frame: state returns to IDLE next cycle, the partial frame is discarded, and status is unchanged. Ticks while en=0 are ignored.
- Async rst mid-frame: all registers return to their reset values immediately.

Test Plan:
- baud_os toggles every 4 clk (bit = 64 clk). Send 0xA5 8N1 -> rx_data=0xA5, rx_valid=1 about 9.6 bit times after the start edge; frame_err=0, parity_err=0.
- par_en=1, par_odd=0. Send 0x03 with parity bit 1 -> parity_err=1. Repeat with parity bit 0 -> parity_err=0, rx_data=0x03.
- Low glitch of 3 ticks on idle line -> FSM returns to IDLE after tc=9, rx_valid stays 0. A subsequent valid 0x5A frame is received correctly.
- Two back-to-back frames 0x11, 0x22 with no rx_rd -> rx_data=0x22, overrun=1. rx_rd -> rx_valid=0, overrun=0. Repeat with rx_rd coinciding with the completion cycle -> overrun=0.
- Stop bit driven 0 on 0xFF frame -> frame_err=1, rx_data=0xFF. A 20-bit-time break -> exactly one frame with rx_data=0x00, frame_err=1.
- Single-tick-wide noise pulse at tc=8 of data bit 2 of 0x00 -> majority rejects it, rx_data=0x00. Deassert en mid-frame, or pulse rst -> no rx_valid; rst clears every output to 0.
